// File: rtl/vram_write_arbiter.sv
// ---------------------------------------------------------------------------
// vram_write_arbiter
//
// Shares the single write port (port A) of the video RAM between two pixel
// requesters with round-robin arbitration, runs a full-memory clear sequence
// and honours a freeze input that suspends every write. Runs on the LCD
// pixel clock.
//
// Ports:
//   i_clk               pixel clock
//   i_rst_n             asynchronous, active-low reset
//   i_freeze            level; blocks all writes, pauses the clear sequence
//   i_clear             clear request, sampled on the rising edge
//   i_req0 / i_req1     write requests
//   i_addr0 / i_addr1   write addresses, stable while the request is high
//   i_dat0 / i_dat1     write data, stable while the request is high
//   o_gnt0 / o_gnt1     combinational ready; write accepted on req & gnt
//   o_mem_addr          registered RAM write address (ada)
//   o_mem_dat           registered RAM write data (din)
//   o_mem_ce            registered RAM write strobe (cea)
//   o_busy              registered; high while a clear is pending or running
// ---------------------------------------------------------------------------
module vram_write_arbiter #(
    parameter int   ADDR_W         = 16,
    parameter logic CLEAR_VAL      = 1'b0,
    parameter bit   CLEAR_ON_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_freeze,
    input  logic              i_clear,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic              i_dat0,
    input  logic              i_dat1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_dat,
    output logic              o_mem_ce,
    output logic              o_busy
);

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic              rr_q,    rr_d;     // requester granted most recently
    logic              ce_q,    ce_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              dat_q,   dat_d;
    logic              busy_q,  busy_d;

    logic win1;
    logic arb_open;
    logic gnt0;
    logic gnt1;
    logic accept;

    // Under contention the requester not granted last wins; a lone request
    // always wins. With no request the value is irrelevant.
    always_comb begin
        win1 = i_req1;
        if (i_req0 && i_req1) begin
            win1 = ~rr_q;
        end
    end

    // A clear request in the same cycle pre-empts any grant.
    assign arb_open = (state_q == ST_ARB) && !i_freeze && !i_clear;
    assign gnt0     = arb_open && i_req0 && !win1;
    assign gnt1     = arb_open && i_req1 &&  win1;
    assign accept   = gnt0 || gnt1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        ce_d    = 1'b0;
        addr_d  = addr_q;
        dat_d   = dat_q;
        busy_d  = busy_q;
        case (state_q)
            ST_ARB: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (accept) begin
                    ce_d   = 1'b1;
                    addr_d = win1 ? i_addr1 : i_addr0;
                    dat_d  = win1 ? i_dat1  : i_dat0;
                    rr_d   = win1;
                end
            end
            ST_CLEAR: begin
                // Freeze simply stalls the counter, so no address is skipped
                // or written twice.
                if (!i_freeze) begin
                    ce_d   = 1'b1;
                    addr_d = cnt_q;
                    dat_d  = CLEAR_VAL;
                    cnt_d  = cnt_q + ADDR_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_ARB;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            rr_q    <= 1'b1;
            ce_q    <= 1'b0;
            addr_q  <= '0;
            dat_q   <= 1'b0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            ce_q    <= ce_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
        end
    end

    assign o_gnt0     = gnt0;
    assign o_gnt1     = gnt1;
    assign o_mem_addr = addr_q;
    assign o_mem_dat  = dat_q;
    assign o_mem_ce   = ce_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/vram_write_arbiter.md
# vram_write_arbiter

Sequencer and arbiter for the video RAM write port (port A of the 64K x 1 video RAM). It shares the single write port between two pixel-writing requesters using round-robin arbitration. It also runs a built-in full-memory clear sequence and provides a freeze input that stops every write. It sits between the pixel producers (noise generator, pattern/drawing engines) and the RAM, and runs on the LCD pixel clock.

## Interface
Parameters:
- ADDR_W, 16, write address width; memory depth is 2^ADDR_W
- CLEAR_VAL, 1'b0, data bit written by the clear sequence
- CLEAR_ON_RESET, 1, 1 = start a clear sequence automatically when reset is released

Ports:
- i_clk  in  1  pixel clock; the only clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_freeze  in  1  level; while high, no write is issued and the clear sequence pauses
- i_clear  in  1  clear request, sampled on the rising edge
- i_req0 / i_req1  in  1  write request from requester 0 / 1
- i_addr0 / i_addr1  in  ADDR_W  write address, held stable while the request is high
- i_dat0 / i_dat1  in  1  write data, held stable while the request is high
- o_gnt0 / o_gnt1  out  1  combinational ready; a write is accepted at a rising edge where req & gnt
- o_mem_addr  out  ADDR_W  registered; drives RAM ada
- o_mem_dat  out  1  registered; drives RAM din
- o_mem_ce  out  1  registered; drives RAM cea (write strobe)
- o_busy  out  1  registered; high while the clear sequence is pending or running

## Operation
- States: ARB, CLEAR.
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET, else ARB
  - clear counter = 0
  - o_mem_ce = 0, o_mem_addr = 0, o_mem_dat = 0
  - o_busy = CLEAR_ON_RESET
  - round-robin pointer = 1, so requester 0 wins the first contest
- ARB:
  - o_gntX = i_reqX & !i_freeze & (X is the winner).
  - Only one request high: that requester wins.
  - Both high: the requester not granted last wins.
  - The pointer updates only on an accepted write.
- Accepted write at an edge: o_mem_ce <= 1, o_mem_addr <= winner address, o_mem_dat <= winner data.
- No accepted write at an edge: o_mem_ce <= 0; o_mem_addr and o_mem_dat hold their values.
- Clear request handling:
  - i_clear high at an edge while in ARB: next state CLEAR, counter <= 0, o_busy <= 1. No grant is issued in that cycle.
  - i_clear and a request on the same cycle: i_clear wins and the request is not accepted.
  - i_clear during CLEAR is ignored; the sequence does not restart.
- CLEAR:
  - o_gnt0 = o_gnt1 = 0.
  - Each edge with !i_freeze: o_mem_ce <= 1, o_mem_addr <= counter, o_mem_dat <= CLEAR_VAL, counter <= counter + 1.
  - Each edge with i_freeze high: o_mem_ce <= 0 and the counter holds.
  - After the edge that issues address 2^ADDR_W - 1: state <= ARB, o_busy <= 0, counter wraps to 0.
  - Exactly 2^ADDR_W clear writes are issued, with no duplicates and no gaps.
- Freeze in ARB: the grants drop in the same cycle, combinationally. A requester keeps its request high and is served after the freeze is released; no write is lost or duplicated.
- Reset asserted mid-clear or mid-write: all state returns to the reset values immediately. A clear in progress restarts from 0 only if CLEAR_ON_RESET = 1.

## Timing
- Write latency: a request accepted at edge N gives o_mem_ce/o_mem_addr/o_mem_dat valid in cycle N+1. The RAM commits the write at edge N+1.
- Throughput: one write per clock, either from a requester or from the clear sequence.
- An uncontended request held high is accepted at the first edge where it is high, provided i_freeze is low and the state is ARB.
- Under continuous contention the grants alternate 0,1,0,1.
- Clear duration with no freeze: 2^ADDR_W cycles of o_mem_ce high, plus 1 cycle for ARB→CLEAR entry.
- After the last clear write, the first grant is possible on the following cycle.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_W=4, no freeze:
  - o_busy=1 from reset.
  - 16 consecutive cycles of o_mem_ce=1 with addresses 0..15 and data CLEAR_VAL.
  - Then o_busy=0.
  - o_gnt0/o_gnt1 stay 0 throughout, even with both requests held high.
- Single requester: i_req0=1, i_addr0=0x0005, i_dat0=1 for one accepted edge → o_gnt0=1; the next cycle shows o_mem_ce=1, o_mem_addr=0x0005, o_mem_dat=1; the cycle after shows o_mem_ce=0.
- Contention: both requests held high for 6 edges → accepted sequence 0,1,0,1,0,1, and o_mem_addr alternates between i_addr0 and i_addr1.
- Freeze mid-clear: with ADDR_W=4, i_freeze high for 3 cycles after the address-7 write → o_mem_ce=0 for those 3 cycles, then addresses resume at 8 and end at 15, for 16 writes total.
- Clear request with a pending write: i_clear and i_req1 on the same edge → i_req1 is not granted; the clear runs fully; i_req1 (still high) is granted on the first cycle back in ARB.
- Async reset asserted at clear address 9: outputs return to reset values without a clock edge, and after release the clear restarts at address 0.
